// File: rtl/result_sender_if.sv
// result_sender_if: read port of the 1-bit result memory (address out, pixel in).
// The sender drives the address through the master modport. The memory
// answers one clock later through the slave modport.
interface result_sender_if #(
    parameter int unsigned WIDTH_BITS  = 8,
    parameter int unsigned HEIGHT_BITS = 8
);
    logic [WIDTH_BITS-1:0]  oResultCol;
    logic [HEIGHT_BITS-1:0] oResultRow;
    logic                   iResultData;

    modport master (output oResultCol, output oResultRow, input iResultData);
    modport slave  (input oResultCol, input oResultRow, output iResultData);
endinterface

// File: rtl/result_sender.sv
// result_sender: reads the binary result image in raster order and sends it
// over a UART line (8N1, LSB first). Each byte packs 8 consecutive pixels,
// with the first pixel in bit 0.
// Optional feature: define RESULT_SENDER_HEADER_EN to send a 4-byte header
// (A5, 5A, WIDTH-1, HEIGHT-1) before the pixel bytes.
module result_sender #(
    parameter int unsigned WIDTH_BITS   = 8,
    parameter int unsigned HEIGHT_BITS  = 8,
    parameter int unsigned WIDTH        = 2**WIDTH_BITS,
    parameter int unsigned HEIGHT       = 2**HEIGHT_BITS,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic             clock,
    input  logic             reset,
    result_sender_if.master  mem,
    input  logic [2:0]       global_state,
    output logic             oTx,
    output logic             oBusy,
    output logic             finished
);
    localparam int unsigned PTR_W  = WIDTH_BITS + HEIGHT_BITS;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(WIDTH*HEIGHT - 8);
    localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [WIDTH_BITS:0]   COL_WRAP  = (WIDTH_BITS+1)'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef RESULT_SENDER_HEADER_EN
        S_HEADER,
`endif
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;        // first pixel of the current byte
    logic [WIDTH_BITS-1:0]   col_q, col_d;        // column of ptr_q
    logic [HEIGHT_BITS-1:0]  row_q, row_d;        // row of ptr_q
    logic [3:0]              fetch_q, fetch_d;    // 0..8 inside FETCH
    logic [7:0]              shift_q, shift_d;    // byte being sent
    logic [2:0]              bit_q, bit_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic                    finished_q, finished_d;

    logic                    go;
    logic                    baud_end;
    logic [WIDTH_BITS:0]     col_step;

    assign go       = (global_state == 3'd2);
    assign baud_end = (baud_q == BAUD_LAST);
    // Bytes never straddle a row because WIDTH is a multiple of 8.
    assign col_step = {1'b0, col_q} + (WIDTH_BITS+1)'(8);

    assign mem.oResultCol = (state_q == S_FETCH) ? col_q + WIDTH_BITS'(fetch_q[2:0]) : col_q;
    assign mem.oResultRow = row_q;
    assign finished       = finished_q;

`ifdef RESULT_SENDER_HEADER_EN
    logic [2:0] hdr_cnt_q, hdr_cnt_d;  // header bytes already sent (4 = header done)
    logic [7:0] hdr_byte;

    // Header byte selected by how many header bytes have gone out.
    always_comb begin
        case (hdr_cnt_q[1:0])
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = 8'h5A;
            2'd2:    hdr_byte = 8'(WIDTH - 1);
            default: hdr_byte = 8'(HEIGHT - 1);
        endcase
    end
`endif

    // State and datapath registers; reset may hit at any point in a byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            fetch_q    <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            baud_q     <= '0;
            finished_q <= 1'b0;
`ifdef RESULT_SENDER_HEADER_EN
            hdr_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            fetch_q    <= fetch_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            baud_q     <= baud_d;
            finished_q <= finished_d;
`ifdef RESULT_SENDER_HEADER_EN
            hdr_cnt_q  <= hdr_cnt_d;
`endif
        end
    end

    // Next-state, fetch/shift/baud sequencing and line outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        col_d      = col_q;
        row_d      = row_q;
        fetch_d    = fetch_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        baud_d     = baud_q;
        finished_d = finished_q;
`ifdef RESULT_SENDER_HEADER_EN
        hdr_cnt_d  = hdr_cnt_q;
`endif
        oTx   = 1'b1;
        oBusy = 1'b1;

        case (state_q)
            S_IDLE: begin
                oBusy = 1'b0;
                if (go && !finished_q) begin
`ifdef RESULT_SENDER_HEADER_EN
                    state_d = (hdr_cnt_q != 3'd4) ? S_HEADER : S_FETCH;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef RESULT_SENDER_HEADER_EN
            S_HEADER: begin
                shift_d = hdr_byte;
                baud_d  = '0;
                state_d = S_START;
            end
`endif
            S_FETCH: begin
                // Data for the address driven in the previous cycle arrives now.
                if (fetch_q != 4'd0) begin
                    shift_d = {mem.iResultData, shift_q[7:1]};
                end
                if (fetch_q == 4'd8) begin
                    fetch_d = '0;
                    baud_d  = '0;
                    state_d = S_START;
                end else begin
                    fetch_d = fetch_q + 4'd1;
                end
            end
            S_START: begin
                oTx = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                oTx = shift_q[bit_q];
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
`ifdef RESULT_SENDER_HEADER_EN
                    if (hdr_cnt_q != 3'd4) begin
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                        if (!go) begin
                            state_d = S_IDLE;
                        end else if (hdr_cnt_q == 3'd3) begin
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_HEADER;
                        end
                    end else
`endif
                    if (ptr_q == LAST_PTR) begin
                        finished_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        // Advance before a possible pause so resume picks up the next byte.
                        ptr_d = ptr_q + PTR_W'(8);
                        if (col_step == COL_WRAP) begin
                            col_d = '0;
                            row_d = row_q + HEIGHT_BITS'(1);
                        end else begin
                            col_d = col_step[WIDTH_BITS-1:0];
                        end
                        state_d = go ? S_FETCH : S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DONE: begin
                oBusy = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
